operand_fetch: RTL and testbench
================================

# operand_fetch

Operand fetch stage for the tinyGPU datapath: the read-side client of `regfile`. It accepts one instruction's register numbers over a valid/ready handshake and drives the `rna`/`rnb`/`rnc` read ports. It holds the instruction while any source or destination has an outstanding write, forwarding write-back data when it arrives. It then presents the three captured 16-bit operands to the execute stage over a second valid/ready handshake.

## Interface
Parameters:
- `DW`, 16, data width (matches regfile word)
- `RW`, 4, register-number width (16 registers)

Ports:
- `clock` in 1: single clock; all state updates on rising edge
- `reset_n` in 1: reset, synchronous and active-low
- `in_valid` in 1: upstream offers an instruction
- `in_ready` out 1: stage can accept this cycle
- `in_rsa`, `in_rsb`, `in_rsc` in RW each: source register numbers
- `in_use` in 3: bit0/1/2 = source a/b/c is used
- `in_rd` in RW: destination register
- `in_wr` in 1: instruction writes `in_rd`
- `rna`, `rnb`, `rnc` out RW each: to regfile read ports
- `qa`, `qb`, `qc` in DW each: regfile read data, combinational on `rn*`
- `wb_we` in 1: write-back strobe (same signals that drive regfile `we`)
- `wb_wn` in RW: write-back register
- `wb_d` in DW: write-back data
- `out_valid` out 1: operands valid
- `out_ready` in 1: execute stage accepts
- `out_a`, `out_b`, `out_c` out DW: operands
- `out_rd` out RW: destination register
- `out_wr` out 1: write flag
- `pending` out 16: scoreboard, bit n = register n has an outstanding write

## Operation
- State machine states: EMPTY, WAIT, FULL.
- `in_ready` = (EMPTY) | (FULL & `out_ready`). A transfer occurs when `in_valid & in_ready`, and it captures all `in_*` into the hold register, next state WAIT.
- `rn*` always drive the held source numbers, with value 0 after reset.
- Source x is clear when either:
  - its `in_use` bit is 0, or
  - `pending[rsx]` = 0, or
  - `wb_we & wb_wn==rsx` in the same cycle.
- The destination is clear when either:
  - `out_wr`-to-be is 0, or
  - `pending[rd]` = 0, or
  - `wb_we & wb_wn==rd` in the same cycle.
- In WAIT, when all three sources and the destination are clear, the stage goes to FULL:
  - Each used operand is latched from `wb_d` if the write-back hits that register this cycle, else from `q*`.
  - Each unused operand is latched as 0.
  - `out_rd` and `out_wr` are latched.
  - If `wr`, then `pending[rd]` is set.
- Otherwise the stage stays in WAIT.
- In FULL, `out_valid` = 1. On `out_ready`, the next state is WAIT if a new instruction is accepted, else EMPTY.
- Scoreboard:
  - `wb_we` clears `pending[wb_wn]`; a clear on a non-pending register is a no-op.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- `out_*` hold their value while `out_valid & !out_ready`. `out_*` are not cleared on leaving FULL.

## Timing
- Reset (`reset_n` low at an edge): state EMPTY, `pending`=0, `out_valid`=0, `out_a/b/c`=0, `out_rd`=0, `out_wr`=0, `rn*`=0.
- `in_ready` is combinational from state and `out_ready`; it is 1 in the first cycle after reset.
- Hazard-free latency: accepted at edge T, WAIT during T..T+1, FULL / `out_valid` high after edge T+1, i.e. 2 cycles.
- Peak throughput: one instruction per 2 cycles.
- Hazard stall: the stage leaves WAIT at the first edge where the blocking write-back is seen. Forwarding means no extra cycle is needed after the write-back.
- Reset mid-operation: the held instruction is dropped, `pending` is cleared, and write-backs in flight are ignored.
- `pending` updates at the same edge as the WAIT→FULL transition.

## Structure
- Shared package `tinygpu_pkg` holds:
  - `DW` and `RW` constants
  - the `of_state_t` enum {EMPTY, WAIT, FULL}
  - the `NREG` = 1<<RW constant
- One sub-module, `op_scoreboard`:
  - ports: `clock`, `reset_n`, set strobe and register, clear strobe and register, `pending` output
  - set-wins priority is implemented inside it
- Operand mux and the state machine live in `operand_fetch`.

## Test plan
- Reset, then send rsa=1, rsb=2, use=011, rd=3, wr=1 with regfile r1=0x1001, r2=0x1002:
  - `out_valid` is high 2 cycles after acceptance
  - out_a=0x1001, out_b=0x1002, out_c=0
  - `pending` = 0x0008
- RAW hazard: with `pending[3]` set, send rsa=3:
  - the stage holds in WAIT with `out_valid` low
  - drive `wb_we`=1, wn=3, d=0xBEEF; `out_valid` rises the next edge with out_a=0xBEEF
  - `pending[3]` is cleared
- WAW: with `pending[5]` set, send rd=5, wr=1:
  - the stage stalls until wb wn=5
  - `pending[5]` remains 1 afterwards (set wins over the same-cycle clear)
- Backpressure: hold `out_ready`=0 for 4 cycles:
  - `out_*` are stable and `in_ready`=0
  - raise `out_ready` with `in_valid` high: the new instruction is accepted the same cycle and the state becomes WAIT
- Unused sources: use=000, rsa=7 with `pending[7]` set:
  - no stall; the result is FULL in 2 cycles with all operands 0
- Reset asserted while in WAIT with `pending`=0x00F0:
  - the next cycle shows `pending`=0, `out_valid`=0, `in_ready`=1

Source files
------------

// File: rtl/tinygpu_pkg.sv
// Shared tinyGPU definitions: datapath widths and the operand-fetch state type.
package tinygpu_pkg;

    localparam int DW   = 16;       // data word width, matches regfile
    localparam int RW   = 4;        // register-number width
    localparam int NREG = 1 << RW;  // number of architectural registers

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2
    } of_state_t;

endpackage

// File: rtl/op_scoreboard.sv
// Outstanding-write scoreboard: one bit per register, set when an instruction
// that writes it leaves operand fetch, cleared by the matching write-back.
module op_scoreboard #(
    parameter int RW = tinygpu_pkg::RW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 set_en,
    input  logic [RW-1:0]        set_reg,
    input  logic                 clr_en,
    input  logic [RW-1:0]        clr_reg,
    output logic [(1<<RW)-1:0]   pending
);

    // Update pending bits; a set and a clear on the same register leave it set.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            // NOTE: both writes are non-blocking to the same vector; the later
            // statement takes effect, which is what gives the set priority.
            if (clr_en) pending[clr_reg] <= 1'b0;
            if (set_en) pending[set_reg] <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: holds one instruction, waits for RAW/WAW hazards to
// clear (forwarding the resolving write-back), then presents its operands.
module operand_fetch #(
    parameter int DW = tinygpu_pkg::DW,
    parameter int RW = tinygpu_pkg::RW
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RW-1:0]       in_rsa,
    input  logic [RW-1:0]       in_rsb,
    input  logic [RW-1:0]       in_rsc,
    input  logic [2:0]          in_use,
    input  logic [RW-1:0]       in_rd,
    input  logic                in_wr,
    output logic [RW-1:0]       rna,
    output logic [RW-1:0]       rnb,
    output logic [RW-1:0]       rnc,
    input  logic [DW-1:0]       qa,
    input  logic [DW-1:0]       qb,
    input  logic [DW-1:0]       qc,
    input  logic                wb_we,
    input  logic [RW-1:0]       wb_wn,
    input  logic [DW-1:0]       wb_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_a,
    output logic [DW-1:0]       out_b,
    output logic [DW-1:0]       out_c,
    output logic [RW-1:0]       out_rd,
    output logic                out_wr,
    output logic [(1<<RW)-1:0]  pending
);

    import tinygpu_pkg::*;

    of_state_t      state;
    of_state_t      state_next;

    // Held instruction
    logic [RW-1:0]  hold_rsa;
    logic [RW-1:0]  hold_rsb;
    logic [RW-1:0]  hold_rsc;
    logic [2:0]     hold_use;
    logic [RW-1:0]  hold_rd;
    logic           hold_wr;

    logic           accept;
    logic           go_full;
    logic           hit_a, hit_b, hit_c, hit_d;
    logic           clear_a, clear_b, clear_c, clear_d;

    // Operand select: unused reads as 0, a same-cycle write-back beats the regfile.
    function automatic logic [DW-1:0] pick_operand(input logic used,
                                                   input logic hit,
                                                   input logic [DW-1:0] wb,
                                                   input logic [DW-1:0] q);
        if (!used)    return '0;
        else if (hit) return wb;
        else          return q;
    endfunction

    assign rna = hold_rsa;
    assign rnb = hold_rsb;
    assign rnc = hold_rsc;

    assign hit_a = wb_we && (wb_wn == hold_rsa);
    assign hit_b = wb_we && (wb_wn == hold_rsb);
    assign hit_c = wb_we && (wb_wn == hold_rsc);
    assign hit_d = wb_we && (wb_wn == hold_rd);

    assign clear_a = !hold_use[0] || !pending[hold_rsa] || hit_a;
    assign clear_b = !hold_use[1] || !pending[hold_rsb] || hit_b;
    assign clear_c = !hold_use[2] || !pending[hold_rsc] || hit_c;
    assign clear_d = !hold_wr     || !pending[hold_rd]  || hit_d;

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        go_full    = 1'b0;
        unique case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WAIT;
            end
            WAIT: begin
                if (clear_a && clear_b && clear_c && clear_d) begin
                    go_full    = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? WAIT : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Capture the offered instruction on a transfer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_rsa <= '0;
            hold_rsb <= '0;
            hold_rsc <= '0;
            hold_use <= '0;
            hold_rd  <= '0;
            hold_wr  <= 1'b0;
        end else if (accept) begin
            hold_rsa <= in_rsa;
            hold_rsb <= in_rsb;
            hold_rsc <= in_rsc;
            hold_use <= in_use;
            hold_rd  <= in_rd;
            hold_wr  <= in_wr;
        end
    end

    // Latch operands and destination when the hazards clear; hold otherwise.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_a  <= '0;
            out_b  <= '0;
            out_c  <= '0;
            out_rd <= '0;
            out_wr <= 1'b0;
        end else if (go_full) begin
            out_a  <= pick_operand(hold_use[0], hit_a, wb_d, qa);
            out_b  <= pick_operand(hold_use[1], hit_b, wb_d, qb);
            out_c  <= pick_operand(hold_use[2], hit_c, wb_d, qc);
            out_rd <= hold_rd;
            out_wr <= hold_wr;
        end
    end

    op_scoreboard #(.RW(RW)) u_scoreboard (
        .clock   (clock),
        .reset_n (reset_n),
        .set_en  (go_full && hold_wr),
        .set_reg (hold_rd),
        .clr_en  (wb_we),
        .clr_reg (wb_wn),
        .pending (pending)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed hazard scenarios plus a
// randomized run against an architectural-level model (regfile + pending set).
module tb_operand_fetch;

    localparam int DW = 16;
    localparam int RW = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           in_valid, in_ready;
    logic [RW-1:0]  in_rsa, in_rsb, in_rsc, in_rd;
    logic [2:0]     in_use;
    logic           in_wr;
    logic [RW-1:0]  rna, rnb, rnc;
    logic [DW-1:0]  qa, qb, qc;
    logic           wb_we;
    logic [RW-1:0]  wb_wn;
    logic [DW-1:0]  wb_d;
    logic           out_valid, out_ready;
    logic [DW-1:0]  out_a, out_b, out_c;
    logic [RW-1:0]  out_rd;
    logic           out_wr;
    logic [15:0]    pending;

    int checks   = 0;
    int failures = 0;

    // Regfile model, written only from the stimulus process.
    logic [DW-1:0]  rf [16];
    logic [15:0]    m_pend;

    assign qa = rf[rna];
    assign qb = rf[rnb];
    assign qc = rf[rnc];

    always #5 clock = ~clock;

    operand_fetch #(.DW(DW), .RW(RW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rsa    (in_rsa),
        .in_rsb    (in_rsb),
        .in_rsc    (in_rsc),
        .in_use    (in_use),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .rna       (rna),
        .rnb       (rnb),
        .rnc       (rnc),
        .qa        (qa),
        .qb        (qb),
        .qc        (qc),
        .wb_we     (wb_we),
        .wb_wn     (wb_wn),
        .wb_d      (wb_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .pending   (pending)
    );

    // One clock: commit the write-back to the regfile just after the edge,
    // then return at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clock);
        #1;
        if (wb_we) rf[wb_wn] = wb_d;
        @(negedge clock);
    endtask

    // Offer one instruction and wait (bounded) for it to be taken.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [2:0] u, input logic [3:0] d, input logic w);
        int n;
        in_rsa = a; in_rsb = b; in_rsc = c; in_use = u; in_rd = d; in_wr = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_accept: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1; in_rsa = 4'd9; in_rsb = 4'd10; in_rsc = 4'd11;
        in_use = 3'b111; in_rd = 4'd12; in_wr = 1'b1;
        wb_we = 1'b1; wb_wn = 4'd3; wb_d = 16'h5555; out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (pending !== 16'h0) begin failures++; $display("FAIL reset_pending: got %h expected 0000", pending); end
        checks++; if ({out_a, out_b, out_c} !== 48'h0) begin failures++; $display("FAIL reset_operands: got %h %h %h expected 0", out_a, out_b, out_c); end
        checks++; if ({out_rd, out_wr} !== 5'h0) begin failures++; $display("FAIL reset_rd_wr: got rd=%h wr=%b expected 0", out_rd, out_wr); end
        checks++; if ({rna, rnb, rnc} !== 12'h0) begin failures++; $display("FAIL reset_rn: got %h %h %h expected 0", rna, rnb, rnc); end
        reset_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL first_cycle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        rf[1] = 16'h1001; rf[2] = 16'h1002;
        out_ready = 1'b0;
        send(4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_wait: out_valid=%b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: out_valid=%b expected 1", out_valid); end
        checks++; if (out_a !== 16'h1001 || out_b !== 16'h1002 || out_c !== 16'h0) begin
            failures++; $display("FAIL basic_operands: got %h %h %h expected 1001 1002 0000", out_a, out_b, out_c); end
        checks++; if (out_rd !== 4'd3 || out_wr !== 1'b1) begin failures++; $display("FAIL basic_rd_wr: got rd=%h wr=%b expected 3 1", out_rd, out_wr); end
        checks++; if (pending !== 16'h0008) begin failures++; $display("FAIL basic_pending: got %h expected 0008", pending); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_raw();
        send(4'd3, 4'd1, 4'd2, 3'b001, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL raw_stall[%0d]: out_valid=%b expected 0", i, out_valid); end
            tick();
        end
        wb_we = 1'b1; wb_wn = 4'd3; wb_d = 16'hBEEF;
        tick();
        wb_we = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL raw_release: out_valid=%b expected 1", out_valid); end
        checks++; if (out_a !== 16'hBEEF || out_b !== 16'h0) begin failures++; $display("FAIL raw_forward: got a=%h b=%h expected BEEF 0000", out_a, out_b); end
        checks++; if (pending !== 16'h0) begin failures++; $display("FAIL raw_pending: got %h expected 0000", pending); end
        tick();
    endtask

    task automatic test_waw();
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1);
        tick();
        tick();
        checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL waw_setup: pending=%h expected 0020", pending); end
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL waw_stall: out_valid=%b expected 0", out_valid); end
        wb_we = 1'b1; wb_wn = 4'd5; wb_d = 16'h0A0A;
        tick();
        wb_we = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd !== 4'd5) begin failures++; $display("FAIL waw_release: valid=%b rd=%h expected 1 5", out_valid, out_rd); end
        checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL waw_set_wins: pending=%h expected 0020", pending); end
        tick();
        wb_we = 1'b1; wb_wn = 4'd5;
        tick();
        wb_we = 1'b0;
        checks++; if (pending !== 16'h0) begin failures++; $display("FAIL waw_clear: pending=%h expected 0000", pending); end
    endtask

    task automatic test_backpressure();
        logic [3:0]  r0, r1, r2;
        logic [15:0] e0, e1, e2;
        r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
        e0 = rf[r0]; e1 = rf[r1]; e2 = rf[r2];
        out_ready = 1'b0;
        send(r0, r1, r2, 3'b111, 4'd1, 1'b0);
        tick();
        in_rsa = 4'd8; in_rsb = 4'd9; in_rsc = 4'd10; in_use = 3'b111; in_rd = 4'd2; in_wr = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b expected 1 0", i, out_valid, in_ready); end
            checks++; if (out_a !== e0 || out_b !== e1 || out_c !== e2) begin
                failures++; $display("FAIL bp_stable[%0d]: got %h %h %h expected %h %h %h", i, out_a, out_b, out_c, e0, e1, e2); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: in_ready=%b expected 1", in_ready); end
        e0 = rf[8]; e1 = rf[9]; e2 = rf[10];
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_accept_wait: valid=%b in_ready=%b expected 0 0", out_valid, in_ready); end
        checks++; if (out_a !== rf[r0]) begin failures++; $display("FAIL bp_not_cleared: out_a=%h expected %h", out_a, rf[r0]); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_a !== e0 || out_b !== e1 || out_c !== e2 || out_rd !== 4'd2) begin
            failures++; $display("FAIL bp_second: valid=%b got %h %h %h rd=%h expected 1 %h %h %h 2", out_valid, out_a, out_b, out_c, out_rd, e0, e1, e2); end
        tick();
    endtask

    task automatic test_unused();
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1);
        tick();
        tick();
        checks++; if (pending !== 16'h0080) begin failures++; $display("FAIL unused_setup: pending=%h expected 0080", pending); end
        send(4'd7, 4'd7, 4'd7, 3'b000, 4'd0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL unused_no_stall: out_valid=%b expected 1", out_valid); end
        checks++; if ({out_a, out_b, out_c} !== 48'h0) begin failures++; $display("FAIL unused_zero: got %h %h %h expected 0", out_a, out_b, out_c); end
        tick();
    endtask

    task automatic test_reset_mid();
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1);
        tick();
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1);
        tick();
        send(4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1);
        tick();
        send(4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 16'h00F0) begin
            failures++; $display("FAIL midreset_setup: valid=%b pending=%h expected 0 00F0", out_valid, pending); end
        reset_n = 1'b0;
        wb_we = 1'b1; wb_wn = 4'd4; wb_d = 16'h7777;
        tick();
        reset_n = 1'b1; wb_we = 1'b0;
        checks++; if (pending !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset: pending=%h valid=%b in_ready=%b expected 0000 0 1", pending, out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 16'h0) begin
            failures++; $display("FAIL midreset_dropped: valid=%b pending=%h expected 0 0000", out_valid, pending); end
    endtask

    // Random instructions, one at a time, with random write-back traffic.
    // Model: an instruction may leave WAIT once none of the registers it
    // needs is outstanding (counting this cycle's write-back as resolving);
    // operands are the architectural register values at that point.
    task automatic test_random();
        logic [3:0]  rs [3];
        logic [3:0]  dst;
        logic [2:0]  u;
        logic        w, blocked, done, need;
        logic [3:0]  reg_k;
        logic [15:0] ex [3];
        logic [15:0] m_next;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_pend = 16'h0;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) rs[k] = 4'($urandom);
            u = 3'($urandom); dst = 4'($urandom); w = 1'($urandom);
            wb_we = 1'b0;
            send(rs[0], rs[1], rs[2], u, dst, w);
            done = 1'b0;
            for (int cyc = 0; cyc < 64 && !done; cyc++) begin
                wb_we = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    wb_we = 1'b1; wb_d = 16'($urandom); wb_wn = 4'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        for (int k = 3; k >= 0; k--) begin
                            reg_k = (k < 3) ? rs[k] : dst;
                            need  = (k < 3) ? u[k] : w;
                            if (need && m_pend[reg_k]) wb_wn = reg_k;
                        end
                    end
                end
                blocked = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    reg_k = (k < 3) ? rs[k] : dst;
                    need  = (k < 3) ? u[k] : w;
                    if (need && m_pend[reg_k] && !(wb_we && wb_wn == reg_k)) blocked = 1'b1;
                end
                for (int k = 0; k < 3; k++)
                    ex[k] = !u[k] ? 16'h0 : ((wb_we && wb_wn == rs[k]) ? wb_d : rf[rs[k]]);
                m_next = m_pend;
                if (wb_we) m_next[wb_wn] = 1'b0;
                if (!blocked && w) m_next[dst] = 1'b1;
                tick();
                m_pend = m_next;
                checks++; if (out_valid !== !blocked) begin
                    failures++; $display("FAIL rand_valid[%0d]: out_valid=%b expected %b", n, out_valid, !blocked); end
                checks++; if (pending !== m_pend) begin
                    failures++; $display("FAIL rand_pending[%0d]: got %h expected %h", n, pending, m_pend); end
                if (!blocked) begin
                    done = 1'b1;
                    checks++; if (out_a !== ex[0] || out_b !== ex[1] || out_c !== ex[2] || out_rd !== dst || out_wr !== w) begin
                        failures++; $display("FAIL rand_result[%0d]: got %h %h %h rd=%h wr=%b expected %h %h %h rd=%h wr=%b",
                                             n, out_a, out_b, out_c, out_rd, out_wr, ex[0], ex[1], ex[2], dst, w); end
                end
            end
            wb_we = 1'b0;
            checks++; if (!done) begin failures++; $display("FAIL rand_timeout[%0d]: out_valid=%b expected 1 within 64 cycles", n, out_valid); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        in_valid = 1'b0; in_rsa = '0; in_rsb = '0; in_rsc = '0; in_use = '0;
        in_rd = '0; in_wr = 1'b0; wb_we = 1'b0; wb_wn = '0; wb_d = '0;
        out_ready = 1'b1; reset_n = 1'b0; m_pend = '0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_raw();
        test_waw();
        test_backpressure();
        test_unused();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
